// File: rtl/clock_period_meter.sv
// rtl/clock_period_meter.sv - measures period and high time of a slow async signal in clkin cycles.
// CLOCK_PERIOD_METER_AVG_EN averages four consecutive periods per start.
module clock_period_meter #(
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 100000000
) (
    input  logic             clkin,
    input  logic             clr_n,
    input  logic             sig_in,
    input  logic             start,
    output logic             busy,
    output logic             valid,
    output logic             timeout,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_MEAS
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   s_dly_q, s_dly_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       period_q, period_d;
    logic [CNT_W-1:0]       high_q, high_d;
    logic                   valid_q, valid_d;
    logic                   timeout_q, timeout_d;
    logic                   s, rise, fall;

`ifdef CLOCK_PERIOD_METER_AVG_EN
    logic [1:0]             rises_q, rises_d;
    logic [CNT_W-1:0]       base_q, base_d;
    logic [CNT_W+1:0]       hsum_q, hsum_d;
`else
    logic [CNT_W-1:0]       hcap_q, hcap_d;
`endif

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~s_dly_q;
    assign fall = ~s & s_dly_q;

    always_comb begin
        state_d   = state_q;
        sync_d    = {sync_q[SYNC_STAGES-2:0], sig_in};
        s_dly_d   = s;
        cnt_d     = cnt_q;
        period_d  = period_q;
        high_d    = high_q;
        valid_d   = 1'b0;
        timeout_d = 1'b0;
`ifdef CLOCK_PERIOD_METER_AVG_EN
        rises_d   = rises_q;
        base_d    = base_q;
        hsum_d    = hsum_q;
`else
        hcap_d    = hcap_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_ARM;
                    cnt_d   = '0;
                end
            end
            ST_ARM: begin
                if (rise) begin
                    state_d = ST_MEAS;
                    cnt_d   = CNT_W'(1);
`ifdef CLOCK_PERIOD_METER_AVG_EN
                    rises_d = 2'd0;
                    base_d  = '0;
                    hsum_d  = '0;
`else
                    hcap_d  = '0;
`endif
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = ST_IDLE;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_MEAS: begin
                cnt_d = cnt_q + CNT_W'(1);
`ifdef CLOCK_PERIOD_METER_AVG_EN
                // cnt runs across the whole window; base marks the latest rise
                if (fall) begin
                    hsum_d = hsum_q + {2'b00, cnt_q - base_q};
                end
                if (rise) begin
                    if (rises_q == 2'd3) begin
                        period_d = {2'b00, cnt_q[CNT_W-1:2]};
                        high_d   = hsum_q[CNT_W+1:2];
                        valid_d  = 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
                        rises_d = rises_q + 2'd1;
                        base_d  = cnt_q;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = ST_IDLE;
                    timeout_d = 1'b1;
                end
`else
                if (fall) begin
                    hcap_d = cnt_q;
                end
                if (rise) begin
                    period_d = cnt_q;
                    high_d   = hcap_q;
                    valid_d  = 1'b1;
                    state_d  = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = ST_IDLE;
                    timeout_d = 1'b1;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clkin or negedge clr_n) begin
        if (!clr_n) begin
            state_q   <= ST_IDLE;
            sync_q    <= '0;
            s_dly_q   <= 1'b0;
            cnt_q     <= '0;
            period_q  <= '0;
            high_q    <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
`ifdef CLOCK_PERIOD_METER_AVG_EN
            rises_q   <= 2'd0;
            base_q    <= '0;
            hsum_q    <= '0;
`else
            hcap_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            s_dly_q   <= s_dly_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            high_q    <= high_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
`ifdef CLOCK_PERIOD_METER_AVG_EN
            rises_q   <= rises_d;
            base_q    <= base_d;
            hsum_q    <= hsum_d;
`else
            hcap_q    <= hcap_d;
`endif
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign valid     = valid_q;
    assign timeout   = timeout_q;
    assign period    = period_q;
    assign high_time = high_q;

endmodule

// File: tb/tb_clock_period_meter.sv
// tb/tb_clock_period_meter.sv - randomized self-checking bench for clock_period_meter.
module tb_clock_period_meter;

    localparam int CNT_W = 32;
`ifdef CLOCK_PERIOD_METER_AVG_EN
    localparam int TB_TIMEOUT = 400;
`else
    localparam int TB_TIMEOUT = 50;
`endif

    logic             clkin  = 1'b0;
    logic             clr_n  = 1'b0;
    logic             sig_in = 1'b0;
    logic             start  = 1'b0;
    logic             busy, valid, timeout;
    logic [CNT_W-1:0] period, high_time;

    int checks = 0;
    int errors = 0;
    int hs[5];
    int ls[5];
    int last_ep = 0;
    int last_eh = 0;

    clock_period_meter #(
        .CNT_W      (CNT_W),
        .SYNC_STAGES(2),
        .TIMEOUT    (TB_TIMEOUT)
    ) dut (
        .clkin    (clkin),
        .clr_n    (clr_n),
        .sig_in   (sig_in),
        .start    (start),
        .busy     (busy),
        .valid    (valid),
        .timeout  (timeout),
        .period   (period),
        .high_time(high_time)
    );

    always #5 clkin = ~clkin;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clkin);
    endtask

    // Expected result straight from the high/low lengths of the stimulus periods
    task automatic model(output int ep, output int eh);
`ifdef CLOCK_PERIOD_METER_AVG_EN
        ep = 0;
        eh = 0;
        for (int i = 0; i < 4; i++) begin
            ep += hs[i] + ls[i];
            eh += hs[i];
        end
        ep = ep / 4;
        eh = eh / 4;
`else
        ep = hs[0] + ls[0];
        eh = hs[0];
`endif
    endtask

    task automatic randomize_wave();
        for (int i = 0; i < 5; i++) begin
            hs[i] = $urandom_range(20, 1);
            ls[i] = $urandom_range(20, 1);
        end
    endtask

    task automatic set_wave(input int h, input int l);
        for (int i = 0; i < 5; i++) begin
            hs[i] = h;
            ls[i] = l;
        end
    endtask

    task automatic measure(input string tag, input int restart_at);
        bit               wq[$];
        int               ep, eh, nvalid, ntimeout, budget;
        logic [CNT_W-1:0] gp, gh;
        logic             gbusy;
        gp = '0; gh = '0; gbusy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            repeat (hs[i]) wq.push_back(1'b1);
            repeat (ls[i]) wq.push_back(1'b0);
        end
        wq.push_back(1'b1);
        model(ep, eh);
        sig_in = 1'b0;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        budget = wq.size() + 30;
        nvalid = 0;
        ntimeout = 0;
        for (int c = 0; c < budget; c++) begin
            if (wq.size() > 0) sig_in = wq.pop_front();
            start = (c == restart_at);
            tick();
            if (valid) begin
                nvalid++;
                if (nvalid == 1) begin
                    gp = period;
                    gh = high_time;
                    gbusy = busy;
                end
            end
            if (timeout) ntimeout++;
        end
        start = 1'b0;
        check({tag, " valid_cnt"}, nvalid, 1);
        check({tag, " period"}, gp, ep);
        check({tag, " high_time"}, gh, eh);
        check({tag, " busy_at_valid"}, gbusy, 0);
        check({tag, " timeout_cnt"}, ntimeout, 0);
        check({tag, " busy_after"}, busy, 0);
        last_ep = ep;
        last_eh = eh;
    endtask

    task automatic timeout_test();
        int n;
        bit seen;
        sig_in = 1'b0;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        check("to busy_armed", busy, 1);
        n = 0;
        seen = 0;
        for (int c = 0; c < TB_TIMEOUT + 20; c++) begin
            tick();
            n++;
            if (timeout) begin
                seen = 1;
                break;
            end
        end
        check("to seen", seen, 1);
        check("to latency", n, TB_TIMEOUT);
        check("to busy", busy, 0);
        check("to valid", valid, 0);
        check("to period_kept", period, last_ep);
        check("to high_kept", high_time, last_eh);
        tick();
        check("to pulse_width", timeout, 0);
    endtask

    task automatic reset_mid_meas();
        set_wave(8, 8);
        sig_in = 1'b0;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        for (int c = 0; c < 12; c++) begin
            sig_in = (c < 8);
            tick();
        end
        check("rst busy_before", busy, 1);
        clr_n = 1'b0;
        #1;
        check("rst busy", busy, 0);
        check("rst valid", valid, 0);
        check("rst timeout", timeout, 0);
        check("rst period", period, 0);
        check("rst high_time", high_time, 0);
        tick();
        clr_n = 1'b1;
        sig_in = 1'b0;
        repeat (5) tick();
        check("rst no_pulse", valid | timeout | busy, 0);
        last_ep = 0;
        last_eh = 0;
    endtask

    initial begin
        #2;
        check("reset busy", busy, 0);
        check("reset valid", valid, 0);
        check("reset timeout", timeout, 0);
        check("reset period", period, 0);
        check("reset high_time", high_time, 0);
        tick();
        clr_n = 1'b1;
        repeat (4) tick();

        set_wave(5, 5);
        measure("sq5", -1);

        set_wave(3, 7);
        measure("h3l7_a", -1);
        measure("h3l7_b", 3);
        measure("h3l7_c", -1);

        for (int r = 0; r < 6; r++) begin
            randomize_wave();
            measure($sformatf("rand%0d", r), (r % 2 == 0) ? 4 : -1);
        end

        hs[0] = 5; ls[0] = 5;
        hs[1] = 5; ls[1] = 5;
        hs[2] = 6; ls[2] = 6;
        hs[3] = 6; ls[3] = 6;
        hs[4] = 5; ls[4] = 5;
        measure("p10_10_12_12", -1);

        timeout_test();
        reset_mid_meas();

        randomize_wave();
        measure("after_rst", -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
